// File: rtl/demux1_2_buf.sv
// 1:2 steering demux with a 2-entry FIFO per output; one-cycle registered latency, no bypass.
// Backpressure: in_ready = en & ~full[in_sel], from registered state only; full target stalls input (head-of-line).
module demux1_2_buf #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNTW-1:0]  cnt_a,
  output logic [CNTW-1:0]  cnt_b
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             state_q [2];
  logic [WIDTH-1:0] mem_q   [2][2];
  logic             wptr_q  [2];
  logic             rptr_q  [2];
  logic [CNTW-1:0]  cnt_q   [2];

  logic [1:0] full;
  logic [1:0] vld;
  logic [1:0] rdy;
  logic [1:0] push;
  logic [1:0] pop;
  logic       accept;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c] = (state_q[c] == FULL);
      vld[c]  = (state_q[c] != EMPTY);
    end
  end

  assign rdy      = {b_ready, a_ready};
  assign in_ready = en & ~full[in_sel];
  assign accept   = in_valid & in_ready;
  assign push     = {accept & in_sel, accept & ~in_sel};
  assign pop      = vld & rdy;

  // Reset wins over any same-cycle push/pop: in-flight words are dropped and storage zeroed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        state_q[c]   <= EMPTY;
        wptr_q[c]    <= 1'b0;
        rptr_q[c]    <= 1'b0;
        cnt_q[c]     <= '0;
        mem_q[c][0]  <= '0;
        mem_q[c][1]  <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem_q[c][wptr_q[c]] <= in_data;
          wptr_q[c]           <= ~wptr_q[c];
          cnt_q[c]            <= cnt_q[c] + 1'b1;
        end
        if (pop[c]) begin
          rptr_q[c] <= ~rptr_q[c];
        end
        case (state_q[c])
          EMPTY: if (push[c]) state_q[c] <= ONE;
          ONE: begin
            if (push[c] && !pop[c])      state_q[c] <= FULL;
            else if (!push[c] && pop[c]) state_q[c] <= EMPTY;
          end
          FULL:    if (pop[c]) state_q[c] <= ONE;
          default: state_q[c] <= EMPTY;
        endcase
      end
    end
  end

  assign a_valid = vld[0];
  assign b_valid = vld[1];
  assign a_data  = mem_q[0][rptr_q[0]];
  assign b_data  = mem_q[1][rptr_q[1]];
  assign cnt_a   = cnt_q[0];
  assign cnt_b   = cnt_q[1];

endmodule
